// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the reusable pipeline stage register.
// State encoding doubles as {skid_valid, main_valid}.
package pipe_stage_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] FULL  = 2'b01;
    localparam logic [1:0] SKID  = 2'b11;

    localparam logic CTRL_NOP = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for bubble statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage latch with a two-entry skid buffer.
// Control is zeroed on empty slots so bubbles act as NOPs.
module pipe_stage_reg #(
    parameter int DATA_WIDTH       = 64,
    parameter int CTRL_WIDTH       = 8,
    parameter int BUBBLE_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [CTRL_WIDTH-1:0]       out_ctrl,
    output logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt
);

    import pipe_stage_pkg::*;

    localparam logic [CTRL_WIDTH-1:0] L_NOP = CTRL_WIDTH'(CTRL_NOP);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_push;
    logic w_pop;
    logic w_bubble;

    assign w_main_valid = (r_state != EMPTY);
    assign w_skid_valid = (r_state == SKID);

    // Ready looks only at registered skid state, never at out_ready.
    assign in_ready = !w_skid_valid && !stall;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_main_valid && out_ready;
    assign w_bubble = out_ready && !w_main_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_main_ctrl <= L_NOP;
            r_skid_ctrl <= L_NOP;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                        r_state     <= FULL;
                    end
                end
                FULL: begin
                    if (w_push && w_pop) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_push) begin
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_state     <= SKID;
                    end else if (w_pop) begin
                        r_main_ctrl <= L_NOP;
                        r_state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_pop) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_skid_ctrl <= L_NOP;
                        r_state     <= FULL;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main_ctrl <= L_NOP;
                    r_skid_ctrl <= L_NOP;
                end
            endcase
        end
    end

    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;

    sat_counter #(
        .WIDTH (BUBBLE_CNT_WIDTH)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubble),
        .clear (1'b0),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: handshake, skid, flush, stall,
// bubble counter saturation and asynchronous reset.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [15:0] bubble_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [63:0] out_data2;
    logic [7:0]  out_ctrl2;
    logic [2:0]  bubble_cnt2;

    int n_checks = 0;
    int n_fails  = 0;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(
        .BUBBLE_CNT_WIDTH (3)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst2_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .out_ctrl   (out_ctrl2),
        .bubble_cnt (bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d,
                         input logic [7:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        rst_n     = 1'b0;
        rst2_n    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 8'h0);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        stall = 1'b1;
        #1;
        chk("rst_in_ready_stall", 64'(in_ready), 64'd0);
        stall = 1'b0;

        step();
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // first beat, one-cycle latency; bubble counted in this cycle
        drive(1'b1, 64'h1234, 8'h5A);
        out_ready = 1'b1;
        step();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", out_data, 64'h1234);
        chk("lat_ctrl", 64'(out_ctrl), 64'h5A);
        chk("lat_bubble", 64'(bubble_cnt), 64'd1);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'(100 + i), 8'(i + 1));
            step();
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_data", out_data, 64'(100 + i));
            chk("b2b_ctrl", 64'(out_ctrl), 64'(i + 1));
            chk("b2b_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 64'h0, 8'h0);
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_data", out_data, 64'd109);
        chk("b2b_bubble", 64'(bubble_cnt), 64'd1);

        // skid: A then B with downstream blocked
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 8'h11);
        step();
        drive(1'b1, 64'hB, 8'h22);
        step();
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        chk("skid_out_data", out_data, 64'hA);
        chk("skid_out_ctrl", 64'(out_ctrl), 64'h11);
        drive(1'b0, 64'h0, 8'h0);
        out_ready = 1'b1;
        step();
        chk("skid_pop1_valid", 64'(out_valid), 64'd1);
        chk("skid_pop1_data", out_data, 64'hB);
        chk("skid_pop1_ctrl", 64'(out_ctrl), 64'h22);
        chk("skid_pop1_ready", 64'(in_ready), 64'd1);
        step();
        chk("skid_pop2_valid", 64'(out_valid), 64'd0);
        chk("skid_pop2_ctrl", 64'(out_ctrl), 64'h0);

        // pop with no refill: ctrl cleared, data held
        out_ready = 1'b0;
        drive(1'b1, 64'hCAFE, 8'h5A);
        step();
        drive(1'b0, 64'h0, 8'h0);
        out_ready = 1'b1;
        step();
        chk("nop_valid", 64'(out_valid), 64'd0);
        chk("nop_ctrl", 64'(out_ctrl), 64'h0);
        chk("nop_data", out_data, 64'hCAFE);
        chk("nop_bubble", 64'(bubble_cnt), 64'd1);

        // flush from SKID with a beat offered
        out_ready = 1'b0;
        drive(1'b1, 64'hD1, 8'h33);
        step();
        drive(1'b1, 64'hD2, 8'h44);
        step();
        chk("fl_skid_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 64'hEE, 8'h77);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 8'h0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'h0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_data", out_data, 64'hD1);
        step();
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // flush from FULL while in_ready=1: offered beat dropped
        drive(1'b1, 64'hF1, 8'h12);
        step();
        flush = 1'b1;
        drive(1'b1, 64'hF2, 8'h34);
        #1;
        chk("fl2_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 8'h0);
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_data", out_data, 64'hF1);
        chk("fl2_ctrl", 64'(out_ctrl), 64'h0);
        chk("fl2_bubble", 64'(bubble_cnt), 64'd1);

        // stall blocks input, held beat still drains
        drive(1'b1, 64'h55, 8'h66);
        step();
        stall = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'h77, 8'h01);
        #1;
        chk("st_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("st_drain_valid", 64'(out_valid), 64'd0);
        chk("st_drain_data", out_data, 64'h55);
        chk("st_bubble0", 64'(bubble_cnt), 64'd1);
        step();
        chk("st_bubble1", 64'(bubble_cnt), 64'd2);
        step();
        chk("st_bubble2", 64'(bubble_cnt), 64'd3);
        step();
        chk("st_bubble3", 64'(bubble_cnt), 64'd4);
        stall = 1'b0;
        drive(1'b0, 64'h0, 8'h0);

        // 3-bit counter saturation on second instance
        rst2_n = 1'b0;
        #1;
        chk("sat_rst", 64'(bubble_cnt2), 64'd0);
        rst2_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) chk("sat_6", 64'(bubble_cnt2), 64'd6);
        end
        chk("sat_10", 64'(bubble_cnt2), 64'd7);
        chk("wide_14", 64'(bubble_cnt), 64'd14);

        // async reset while in SKID
        out_ready = 1'b0;
        drive(1'b1, 64'h81, 8'h18);
        step();
        drive(1'b1, 64'h82, 8'h28);
        step();
        chk("rs_skid_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 64'h0, 8'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_data", out_data, 64'h0);
        chk("rs_ctrl", 64'(out_ctrl), 64'h0);
        chk("rs_bubble", 64'(bubble_cnt), 64'd0);
        chk("rs_ready", 64'(in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'h99, 8'h09);
        step();
        chk("rs_new_data", out_data, 64'h99);
        drive(1'b0, 64'h0, 8'h0);
        step();
        chk("rs_empty1", 64'(out_valid), 64'd0);
        step();
        chk("rs_empty2", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
